// File: rtl/imem_loader.sv
// Serial IMEM loader: framed UART bytes -> big-endian 32-bit words -> IMEM write port, ACK byte back over UART.
// Latency: wr_en one cycle after a word's 4th byte; cpu_hold one cycle after load_en; tx_start as soon as tx_busy is low in ACK.
// Backpressure: rx is never stalled (every strobe consumed); the ACK strobe waits while tx_busy is high.
module imem_loader #(
    parameter int         IMEM_DEPTH     = 256,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] MAGIC          = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, MAGIC_W, COUNT, DATA, CHECK, ACK, FIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   n_words;    // one bit wider than the index so N=0 can mean IMEM_DEPTH
    logic [AW:0]   word_idx;
    logic [1:0]    byte_cnt;
    logic [23:0]   word_acc;   // first three bytes of the word in flight
    logic [7:0]    csum;
    logic [TW-1:0] idle_cnt;
    logic          timed;
    logic          timeout;
    logic          byte_last;
    logic          word_last;

    // Idle timer only runs once the frame has really started (after MAGIC).
    assign timed     = (state == COUNT) || (state == DATA) || (state == CHECK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout   = timed && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign byte_last = (byte_cnt == 2'd3);
    assign word_last = (word_idx == (n_words - (AW+1)'(1)));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; dropping load_en aborts before any byte is looked at.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_en) state_nxt = MAGIC_W;
            MAGIC_W: if (!load_en) state_nxt = IDLE;
                     else if (rx_valid && (rx_data == MAGIC)) state_nxt = COUNT;
            COUNT:   if (!load_en) state_nxt = IDLE;
                     else if (rx_valid) state_nxt = DATA;
                     else if (timeout) state_nxt = ACK;
            DATA:    if (!load_en) state_nxt = IDLE;
                     else if (rx_valid && byte_last && word_last) state_nxt = CHECK;
                     else if (timeout) state_nxt = ACK;
            CHECK:   if (!load_en) state_nxt = IDLE;
                     else if (rx_valid || timeout) state_nxt = ACK;
            ACK:     if (!tx_busy) state_nxt = FIN;
            FIN:     if (!load_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs: CPU held through the whole load until the ACK strobe leaves.
    always_comb begin
        cpu_hold = (state == MAGIC_W) || (state == COUNT) || (state == DATA) ||
                   (state == CHECK) || (state == ACK);
        tx_start = (state == ACK) && !tx_busy;
    end

    // Datapath: idle timer, word assembly, checksum, write port and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data  <= 8'd0;
            wr_en    <= 1'b0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= 2'd0;
            word_acc <= 24'd0;
            csum     <= 8'd0;
            idle_cnt <= '0;
        end else begin
            wr_en <= 1'b0;

            if (timed && !rx_valid) idle_cnt <= idle_cnt + TW'(1);
            else                    idle_cnt <= '0;

            if (load_en && timeout) begin
                err     <= 1'b1;
                tx_data <= 8'h15;
            end

            case (state)
                IDLE: if (load_en) begin
                    done     <= 1'b0;
                    err      <= 1'b0;
                    word_idx <= '0;
                    byte_cnt <= 2'd0;
                    csum     <= 8'd0;
                end
                COUNT: if (load_en && rx_valid) begin
                    n_words <= (rx_data == 8'd0) ? (AW+1)'(IMEM_DEPTH) : (AW+1)'(rx_data);
                end
                DATA: if (load_en && rx_valid) begin
                    word_acc <= {word_acc[15:0], rx_data};
                    csum     <= csum + rx_data;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_last) begin
                        wr_en    <= 1'b1;
                        wr_data  <= {word_acc, rx_data};
                        wr_addr  <= {{(30-AW){1'b0}}, word_idx[AW-1:0], 2'b00};
                        word_idx <= word_idx + (AW+1)'(1);
                    end
                end
                CHECK: if (load_en && rx_valid) begin
                    if (rx_data == csum) begin
                        done    <= 1'b1;
                        tx_data <= 8'h06;
                    end else begin
                        err     <= 1'b1;
                        tx_data <= 8'h15;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader that writes the instruction memory through its write port, the writer-side counterpart of the CPU's instruction-fetch read path. It takes bytes from the UART receiver, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses starting at 0x00000000. It holds the CPU in reset while loading. When loading ends it returns a one-byte acknowledge through the UART transmitter.

## Interface
- IMEM_DEPTH, 256 — instruction memory depth in words; word index = wr_addr[9:2].
- TIMEOUT_CYCLES, 1000000 — maximum number of idle clk cycles allowed between bytes once a frame has started.
- MAGIC, 8'hA5 — frame start byte.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_en  in  1  level; high = loader mode requested.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe from the UART receiver.
- tx_busy  in  1  UART transmitter busy.
- tx_data  out  8  acknowledge byte.
- tx_start  out  1  one-cycle strobe that starts transmission of tx_data.
- wr_en  out  1  instruction memory write strobe, one cycle wide.
- wr_addr  out  32  byte address, always word aligned (bits 1:0 = 0).
- wr_data  out  32  instruction word.
- cpu_hold  out  1  holds the CPU core in reset while high.
- done  out  1  sticky; set when a load passes its checksum.
- err  out  1  sticky; set on checksum failure or timeout.

## Operation
- Frame format, in byte order:
  - MAGIC.
  - N, the word count; 0 means 256.
  - 4×N data bytes, most significant byte first.
  - CK, the 8-bit modulo-256 sum of all data bytes.
- States: IDLE, MAGIC_W, COUNT, DATA, CHECK, ACK, FIN.
- IDLE: when load_en is high, clear done, err, the word counter and the checksum; assert cpu_hold; go to MAGIC_W.
- MAGIC_W: a byte equal to MAGIC → COUNT. Any other byte is discarded. The timeout does not run in this state.
- COUNT: latch N; → DATA.
- DATA: shift each byte into the word register. The accumulating checksum adds every data byte. On the 4th byte of a word:
  - wr_en is high on the next cycle, with wr_data = assembled word and wr_addr = 4×word index.
  - The word index then increments.
  - After word N−1 is written → CHECK.
- CHECK: if CK equals the accumulated checksum, set done and load tx_data = 8'h06. Otherwise set err and load tx_data = 8'h15. Either way → ACK.
- ACK: wait for tx_busy low, pulse tx_start for one cycle, → FIN.
- FIN: release cpu_hold once the ACK byte has been issued. Stay in FIN until load_en goes low, then → IDLE. rx bytes received in FIN are ignored.
- Timeout: in COUNT, DATA or CHECK, if the idle counter reaches TIMEOUT_CYCLES, set err, set tx_data = 8'h15, → ACK. The counter clears on every rx_valid.
- Abort: load_en low in MAGIC_W, COUNT, DATA or CHECK → IDLE. cpu_hold drops, err is not set, no ACK is sent. Words already written stay in memory.
- Overflow: N never exceeds IMEM_DEPTH by construction, so the write address wraps only inside memory.

## Timing
- Reset values:
  - outputs: tx_data = 0, tx_start = 0, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_hold = 0, done = 0, err = 0.
  - internal: state = IDLE, all counters = 0.
- Reset asserted mid-load:
  - All of the above take effect immediately (asynchronous).
  - cpu_hold drops, which restarts the CPU.
- Latencies and pulse widths:
  - cpu_hold rises 1 cycle after load_en is sampled high in IDLE.
  - wr_en is exactly 1 cycle wide, 1 cycle after the rx_valid of a word's 4th byte.
  - tx_start is 1 cycle wide, no earlier than 1 cycle after the CK byte. It is delayed for as long as tx_busy stays high.
- Minimum rx_valid spacing is 1 cycle: back-to-back strobes on consecutive cycles are all accepted.
- If rx_valid and the timeout expiry fall on the same cycle, the byte wins and the counter clears.
- If load_en falls and rx_valid arrives on the same cycle, the abort wins and the byte is dropped.

## Test plan
- Two-word load, bytes A5 02 08 00 00 03 24 08 00 40 then CK 0x77:
  - writes 0x08000003 at address 0 and 0x24080040 at address 4;
  - tx_data = 0x06, done = 1, err = 0;
  - cpu_hold is high from the first cycle after load_en until the ACK is issued.
- The same frame with CK = 0x78: both words are still written, err = 1, done = 0, tx_data = 0x15.
- N = 0 with 1024 data bytes: exactly 256 wr_en pulses, the last at wr_addr = 0x3FC; done = 1.
- Bytes 11 22 before A5: the first two bytes are ignored and the load proceeds normally. The load stalls after 3 data bytes with TIMEOUT_CYCLES = 50 → err = 1 and 0x15 is sent 50 cycles after the last byte.
- Back-to-back rx_valid every cycle, with tx_busy held high for 20 cycles at CHECK: all words are correct and tx_start fires on the first cycle tx_busy is low.
- Reset asserted during DATA, then released: all outputs are 0 and state is IDLE. Deasserting load_en mid-frame → IDLE, with no tx_start and err = 0.
